// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - state encoding and default operand width
package shift_add_multiplier_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fulladder_n.sv
// rtl/fulladder_n.sv - full-adder cell whose 'a' input is gated by mgate
module fulladder_n (
   input  logic a,
   input  logic b,
   input  logic mgate,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic ag;

   assign ag   = a & mgate;
   assign s    = ag ^ b ^ cin;
   assign cout = (ag & b) | (cin & (ag ^ b));

endmodule

// File: rtl/mult_add_row.sv
// rtl/mult_add_row.sv - one ripple row of gated full adders: sum = b + (a & mgate)
module mult_add_row
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mgate,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fulladder_n u_fa (
         .a     (a[i]),
         .b     (b[i]),
         .mgate (mgate),
         .cin   (carry[i]),
         .s     (sum[i]),
         .cout  (carry[i+1])
      );
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-add multiplier, one bit per clock
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   state_t             state, state_nxt;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc, acc_step;
   logic [WIDTH-1:0]   mcand, row_sum;
   logic               row_cout;
   logic               last_step;

   mult_add_row #(.WIDTH(WIDTH)) u_row (
      .a     (mcand),
      .b     (acc[2*WIDTH-1:WIDTH]),
      .mgate (acc[0]),
      .sum   (row_sum),
      .cout  (row_cout)
   );

   // Row carry becomes the new accumulator MSB; the consumed multiplier bit falls off the bottom.
   assign acc_step  = {row_cout, row_sum, acc[WIDTH-1:1]};
   assign last_step = (count == CW'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)     state_nxt = ST_RUN;
         ST_RUN:  if (last_step) state_nxt = ST_DONE;
         ST_DONE:                state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         count   <= '0;
         acc     <= '0;
         mcand   <= '0;
         product <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mcand <= multiplicand;
                  acc   <= {{WIDTH{1'b0}}, multiplier};
                  count <= '0;
               end
            end
            ST_RUN: begin
               acc   <= acc_step;
               count <= count + 1'b1;
               // Publish the final step's result directly so product never shows a partial sum.
               if (last_step) product <= acc_step;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == ST_RUN) || (state == ST_DONE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier at WIDTH 4, 8 and 16
module tb_shift_add_multiplier;

   logic        clk;
   logic        rst_n;
   logic        start4, start8, start16;
   logic [15:0] a_in, b_in;
   logic        busy4, busy8, busy16;
   logic        done4, done8, done16;
   logic [7:0]  prod4;
   logic [15:0] prod8;
   logic [31:0] prod16;

   int n_checks = 0;
   int n_fail   = 0;

   shift_add_multiplier #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4),
      .multiplicand(a_in[3:0]), .multiplier(b_in[3:0]),
      .busy(busy4), .done(done4), .product(prod4)
   );

   shift_add_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8),
      .multiplicand(a_in[7:0]), .multiplier(b_in[7:0]),
      .busy(busy8), .done(done8), .product(prod8)
   );

   shift_add_multiplier #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16),
      .multiplicand(a_in), .multiplier(b_in),
      .busy(busy16), .done(done16), .product(prod16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          w;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic get_done(input int w);
      case (w)
         4:       return done4;
         16:      return done16;
         default: return done8;
      endcase
   endfunction

   function automatic logic get_busy(input int w);
      case (w)
         4:       return busy4;
         16:      return busy16;
         default: return busy8;
      endcase
   endfunction

   function automatic logic [31:0] get_prod(input int w);
      case (w)
         4:       return {24'b0, prod4};
         16:      return prod16;
         default: return {16'b0, prod8};
      endcase
   endfunction

   task automatic set_start(input int w, input logic v);
      case (w)
         4:       start4  = v;
         16:      start16 = v;
         default: start8  = v;
      endcase
   endtask

   // One full operation from an idle DUT: latency, busy span, single done, result, hold.
   task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input string tag);
      int          lat, busy_cycles, done_cycles;
      logic [31:0] p;
      lat = -1; busy_cycles = 0; done_cycles = 0; p = '0;
      @(negedge clk);
      a_in = a; b_in = b;
      set_start(w, 1'b1);
      @(negedge clk);
      set_start(w, 1'b0);
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      for (int k = 1; k <= w + 4; k++) begin
         if (get_busy(w)) busy_cycles++;
         if (get_done(w)) begin
            done_cycles++;
            if (lat < 0) begin
               lat = k;
               p   = get_prod(w);
            end
         end
         @(negedge clk);
      end
      check({tag, " latency"}, lat, w + 1);
      check({tag, " product"}, p, exp);
      check({tag, " busy cycles"}, busy_cycles, w + 1);
      check({tag, " done pulses"}, done_cycles, 1);
      check({tag, " product held"}, get_prod(w), exp);
   endtask

   vec_t        vecs[$];
   int          n_done, n_busy, first, t1, t2, stable_bad;
   logic [31:0] got, p1, p2;
   logic [15:0] ra, rb;

   initial begin
      rst_n = 1'b0;
      start4 = 1'b0; start8 = 1'b0; start16 = 1'b0;
      a_in = '0; b_in = '0;

      vecs.push_back('{8,  16'h000F, 16'h000F, 32'h0000_00E1});
      vecs.push_back('{8,  16'h00FF, 16'h00FF, 32'h0000_FE01});
      vecs.push_back('{8,  16'h0000, 16'h00AB, 32'h0000_0000});
      vecs.push_back('{8,  16'h00AB, 16'h0000, 32'h0000_0000});
      vecs.push_back('{8,  16'h0001, 16'h00FF, 32'h0000_00FF});
      vecs.push_back('{8,  16'h0080, 16'h0080, 32'h0000_4000});
      vecs.push_back('{4,  16'h000F, 16'h000F, 32'h0000_00E1});
      vecs.push_back('{4,  16'h0003, 16'h0005, 32'h0000_000F});
      vecs.push_back('{16, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001});
      vecs.push_back('{16, 16'h1234, 16'h0010, 32'h0001_2340});

      repeat (2) @(negedge clk);
      check("reset busy8", busy8, 0);
      check("reset done8", done8, 0);
      check("reset prod8", prod8, 0);
      check("reset busy4", busy4, 0);
      check("reset prod16", prod16, 0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i])
         run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

      // Start pulsed again mid-run with new operands must be ignored.
      run_op(8, 16'h000F, 16'h000F, 32'h00E1, "t4 pre");
      @(negedge clk);
      a_in = 16'h0012; b_in = 16'h0034; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n_done = 0; first = -1; got = '0;
      for (int k = 1; k <= 30; k++) begin
         if (k == 3) begin a_in = 16'h0099; b_in = 16'h0099; start8 = 1'b1; end
         if (k == 4) start8 = 1'b0;
         if (k == 5) check("t4 product hidden mid-op", prod8, 32'h00E1);
         if (done8) begin
            n_done++;
            if (first < 0) begin first = k; got = prod8; end
         end
         @(negedge clk);
      end
      check("t4 done pulses", n_done, 1);
      check("t4 latency", first, 9);
      check("t4 product", got, 32'h03A8);

      // Asynchronous reset in the middle of a run aborts it.
      @(negedge clk);
      a_in = 16'h0055; b_in = 16'h0003; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5 busy after reset", busy8, 0);
      check("t5 done after reset", done8, 0);
      check("t5 product after reset", prod8, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0; n_busy = 0;
      for (int k = 0; k < 20; k++) begin
         if (done8) n_done++;
         if (busy8) n_busy++;
         @(negedge clk);
      end
      check("t5 no done after abort", n_done, 0);
      check("t5 no busy after abort", n_busy, 0);
      run_op(8, 16'h0003, 16'h0005, 32'h000F, "t5 next");

      // Start held high: back-to-back operations.
      @(negedge clk);
      a_in = 16'h0010; b_in = 16'h0010; start8 = 1'b1;
      @(negedge clk);
      a_in = 16'h0007; b_in = 16'h0009;
      t1 = -1; t2 = -1; stable_bad = 0; n_done = 0; p1 = '0; p2 = '0;
      for (int k = 1; k <= 40; k++) begin
         if (done8) begin
            n_done++;
            if (t1 < 0) begin
               t1 = k; p1 = prod8;
            end else if (t2 < 0) begin
               t2 = k; p2 = prod8; start8 = 1'b0;
            end
         end else if (t1 >= 0 && t2 < 0 && prod8 !== 16'h0100) begin
            stable_bad++;
         end
         @(negedge clk);
      end
      start8 = 1'b0;
      check("t6 first latency", t1, 9);
      check("t6 first product", p1, 32'h0100);
      check("t6 second product", p2, 32'h003F);
      check("t6 done spacing", t2 - t1, 10);
      check("t6 product stable", stable_bad, 0);
      check("t6 done count", n_done, 2);

      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom_range(0, 255));
         rb = 16'($urandom_range(0, 255));
         run_op(8, ra, rb, 32'(ra) * 32'(rb), $sformatf("rnd8 %0d %0h*%0h", i, ra, rb));
      end
      for (int i = 0; i < 100; i++) begin
         ra = 16'($urandom_range(0, 15));
         rb = 16'($urandom_range(0, 15));
         run_op(4, ra, rb, 32'(ra) * 32'(rb), $sformatf("rnd4 %0d %0h*%0h", i, ra, rb));
      end
      for (int i = 0; i < 100; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_op(16, ra, rb, 32'(ra) * 32'(rb), $sformatf("rnd16 %0d %0h*%0h", i, ra, rb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
